ham_secded_dec: RTL and testbench
=================================

# ham_secded_dec

Parametrised, pipelined SECDED (Hamming plus overall parity) decoder for the Dynamic-TMR protection path. It accepts one codeword per cycle over a valid/ready handshake and corrects any single-bit error. It detects any double-bit error, reports the error position, and keeps saturating corrected/uncorrectable event counters. It supersedes the fixed (14,10) SEC decoder; for DATA_W=10 the lower 14 codeword bits use the same layout.

## Interface
- DATA_W, 10: payload width, 4..57.
- PAR_W, derived: smallest p with 2^p >= DATA_W+p+1 (4 for DATA_W=10).
- CW_W, derived: DATA_W+PAR_W+1 (15 for DATA_W=10).
- CNT_W, 16: event counter width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept.
- code_i  in  CW_W  codeword.
- corr_en  in  1  1 = correct single errors; 0 = detect only.
- cnt_clr  in  1  synchronous clear of both counters.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- data_o  out  DATA_W  decoded payload.
- err_corr  out  1  single error found (and corrected if corr_en).
- err_uncorr  out  1  double or invalid-position error.
- err_pos  out  PAR_W  Hamming syndrome (1-based bit position, 0 = none or overall-parity bit).
- corr_cnt  out  CNT_W  count of err_corr results.
- uncorr_cnt  out  CNT_W  count of err_uncorr results.

## Operation
- Layout: Hamming positions 1..CW_W-1 map to code_i[pos-1]. Power-of-two positions hold parity; other positions hold data bits in ascending order. code_i[CW_W-1] holds the overall even parity of all other bits.
- Stage 1 registers code_i, syndrome s (XOR of positions whose index has bit k set, for each k), pe = XOR of all CW_W bits, and corr_en.
- Stage 2 classifies the result:
  - s=0, pe=0: clean. Both flags 0.
  - pe=1, s=0: overall-parity bit error. err_corr=1, data unchanged.
  - pe=1, 1<=s<=CW_W-1: single error. err_corr=1; flip bit s-1 if corr_en.
  - pe=1, s>CW_W-1: err_uncorr=1.
  - pe=0, s!=0: double error. err_uncorr=1.
- When err_uncorr=1 or corr_en=0, data_o carries the raw extracted data bits.
- err_pos = s in every case.
- Counters increment by 1 on each stage-2 handshake (out_valid&&out_ready) whose flag is set. They saturate at all-ones. cnt_clr has priority over increment in the same cycle.
- err_corr and err_uncorr are mutually exclusive.

## Timing
- Reset: in_ready=1 after release; out_valid=0, data_o=0, err_corr=0, err_uncorr=0, err_pos=0, counters=0. Stage-1 valid clears.
- Latency: 2 cycles from input handshake to out_valid with out_ready held high. Throughput 1 codeword/cycle.
- The pipeline stalls as a whole:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - Both stages hold while advance=0.
  - Bubbles are not collapsed.
- While out_valid=1 and out_ready=0, all outputs stay stable.
- corr_en is sampled with the codeword at the input handshake. A later change does not affect in-flight words.
- Asserting rst_n low mid-stream discards all in-flight words immediately. No output is produced for them.
- in_valid while in_ready=0 has no effect; the source must hold the word.

## Test plan
- Clean word, DATA_W=10: code_i=0x431A (payload 50) -> after 2 cycles data_o=50, both flags 0, err_pos=0.
- Single data-bit error: code_i=0x430A (bit 4 flipped) -> data_o=50, err_corr=1, err_pos=5, corr_cnt=1. Repeat with corr_en=0 -> data_o=48 (raw payload with data bit 1 cleared), err_corr=1.
- Overall-parity error: code_i=0x031A -> data_o=50, err_corr=1, err_pos=0. Double error: code_i=0x410A (bits 4 and 9 flipped) -> err_uncorr=1, err_pos=15, uncorr_cnt=1.
- Back-pressure: stream 4 words with out_ready low for cycles 3-5 -> no loss or duplication, outputs stable while stalled, in_ready=0 exactly while out_valid&&!out_ready.
- Counter saturation/clear: CNT_W=2, drive 5 single-error words -> corr_cnt stops at 3. cnt_clr asserted in the same cycle as an error handshake -> counter reads 0 next cycle.
- Reset mid-stream: drop rst_n with 2 words in flight -> out_valid=0 immediately. After release, the first new word emerges with 2-cycle latency.

Source files
------------

// File: rtl/ham_secded_dec_if.sv
// Handshake and result bundle for the SECDED decoder; the codeword source and the
// result sink sit on the master side, the decoder on the slave side.
interface ham_secded_dec_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
);
    localparam int PAR_W = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6;
    localparam int CW_W  = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   code_i;
    logic              corr_en;
    logic              cnt_clr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_o;
    logic              err_corr;
    logic              err_uncorr;
    logic [PAR_W-1:0]  err_pos;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    modport master (
        output in_valid, code_i, corr_en, cnt_clr, out_ready,
        input  in_ready, out_valid, data_o, err_corr, err_uncorr, err_pos,
               corr_cnt, uncorr_cnt
    );

    modport slave (
        input  in_valid, code_i, corr_en, cnt_clr, out_ready,
        output in_ready, out_valid, data_o, err_corr, err_uncorr, err_pos,
               corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/ham_secded_dec.sv
// Two-stage SECDED decoder: stage 1 captures syndrome/overall parity, stage 2 classifies,
// corrects and extracts the payload. Both stages stall together on output back-pressure.
module ham_secded_dec #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    ham_secded_dec_if.slave bus
);
    localparam int PAR_W = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6;
    localparam int CW_W  = DATA_W + PAR_W + 1;

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = cw[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    logic              advance;
    logic              v1_q;
    logic [CW_W-1:0]   code1_q;
    logic [PAR_W-1:0]  syn1_q;
    logic              pe1_q;
    logic              ce1_q;
    logic [PAR_W-1:0]  syn_d;
    logic              pe_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              corr_q,   corr_d;
    logic              uncorr_q, uncorr_d;
    logic [PAR_W-1:0]  pos_q;
    logic [CNT_W-1:0]  corr_cnt_q, uncorr_cnt_q;
    logic [CW_W-1:0]   cw_fix;

    assign advance = !out_valid_q || bus.out_ready;

    always_comb begin
        syn_d = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (pos[k]) syn_d[k] = syn_d[k] ^ bus.code_i[pos-1];
            end
        end
        pe_d = ^bus.code_i;
    end

    // Syndromes beyond the last Hamming position cannot come from a single flip.
    always_comb begin
        cw_fix   = code1_q;
        corr_d   = 1'b0;
        uncorr_d = 1'b0;
        if (pe1_q) begin
            if (syn1_q == '0) begin
                corr_d = 1'b1;
            end else if (int'(syn1_q) <= CW_W - 1) begin
                corr_d = 1'b1;
                if (ce1_q) begin
                    for (int i = 0; i < CW_W - 1; i++) begin
                        if (int'(syn1_q) == i + 1) cw_fix[i] = !cw_fix[i];
                    end
                end
            end else begin
                uncorr_d = 1'b1;
            end
        end else if (syn1_q != '0) begin
            uncorr_d = 1'b1;
        end
        data_d = extract(cw_fix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            code1_q <= '0;
            syn1_q  <= '0;
            pe1_q   <= 1'b0;
            ce1_q   <= 1'b0;
        end else if (advance) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                code1_q <= bus.code_i;
                syn1_q  <= syn_d;
                pe1_q   <= pe_d;
                ce1_q   <= bus.corr_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            corr_q      <= 1'b0;
            uncorr_q    <= 1'b0;
            pos_q       <= '0;
        end else if (advance) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                data_q   <= data_d;
                corr_q   <= corr_d;
                uncorr_q <= uncorr_d;
                pos_q    <= syn1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            if (corr_q && (corr_cnt_q != '1))     corr_cnt_q   <= corr_cnt_q + 1'b1;
            if (uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
        end
    end

    assign bus.in_ready   = advance;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_o     = data_q;
    assign bus.err_corr   = corr_q;
    assign bus.err_uncorr = uncorr_q;
    assign bus.err_pos    = pos_q;
    assign bus.corr_cnt   = corr_cnt_q;
    assign bus.uncorr_cnt = uncorr_cnt_q;
endmodule

// File: tb/tb_ham_secded_dec.sv
// Bench for ham_secded_dec (DATA_W=10): directed vectors, back-pressure, counter
// saturation on a CNT_W=2 twin, mid-stream reset, then random traffic vs a reference model.
module tb_ham_secded_dec;
    localparam int DW = 10;
    localparam int CW = 15;

    typedef struct {
        logic [DW-1:0] data;
        logic          corr;
        logic          uncorr;
        logic [3:0]    pos;
        int            cyc;
        int            stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = !clk;

    ham_secded_dec_if #(.DATA_W(DW), .CNT_W(16)) bm ();
    ham_secded_dec_if #(.DATA_W(DW), .CNT_W(2))  bs ();

    assign bs.in_valid  = bm.in_valid;
    assign bs.code_i    = bm.code_i;
    assign bs.corr_en   = bm.corr_en;
    assign bs.cnt_clr   = bm.cnt_clr;
    assign bs.out_ready = bm.out_ready;

    ham_secded_dec #(.DATA_W(DW), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bm));
    ham_secded_dec #(.DATA_W(DW), .CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t cur_exp;
    int   cyc_n = 0;
    int   stall_n = 0;
    int   mc16 = 0, mu16 = 0, mc2 = 0, mu2 = 0;
    logic last_in_hs = 1'b0;
    logic stalled_prev = 1'b0;
    logic [16:0] hold_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] extract(input logic [CW-1:0] cw);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++)
            if ((pos & (pos - 1)) != 0) begin
                d[j] = cw[pos-1];
                j++;
            end
        return d;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] pl);
        logic [CW-1:0] cw;
        logic p;
        int j;
        cw = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++)
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = pl[j];
                j++;
            end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < CW; pos++)
                if (pos[k] && ((pos & (pos - 1)) != 0)) p = p ^ cw[pos-1];
            cw[(1 << k) - 1] = p;
        end
        cw[CW-1] = ^cw[CW-2:0];
        return cw;
    endfunction

    function automatic exp_t mk(input logic [DW-1:0] d, input logic c, input logic u,
                                input logic [3:0] p);
        exp_t e;
        e = '{default: 0};
        e.data = d; e.corr = c; e.uncorr = u; e.pos = p;
        return e;
    endfunction

    // Expected result derived from which bits were flipped in a clean codeword.
    function automatic exp_t model(input logic [DW-1:0] pl, input logic [CW-1:0] mask,
                                   input logic ce);
        logic [CW-1:0] cw;
        int s, nf;
        exp_t e;
        cw = encode(pl) ^ mask;
        s = 0;
        nf = 0;
        for (int i = 0; i < CW; i++)
            if (mask[i]) begin
                nf++;
                if (i < CW - 1) s = s ^ (i + 1);
            end
        e = '{default: 0};
        e.pos = s[3:0];
        if (nf == 0) e.data = pl;
        else if ((nf % 2 == 1) && s == 0) begin e.corr = 1'b1; e.data = pl; end
        else if ((nf % 2 == 1) && s <= CW - 1) begin
            e.corr = 1'b1;
            e.data = ce ? pl : extract(cw);
        end else begin
            e.uncorr = 1'b1;
            e.data = extract(cw);
        end
        return e;
    endfunction

    task automatic cyc();
        logic ih, oh, fc, fu;
        exp_t e;
        #1;
        ih = bm.in_valid && bm.in_ready;
        oh = bm.out_valid && bm.out_ready;
        fc = 1'b0;
        fu = 1'b0;
        chk("in_ready", bm.in_ready, !(bm.out_valid && !bm.out_ready));
        chk("corr_cnt", bm.corr_cnt, mc16);
        chk("uncorr_cnt", bm.uncorr_cnt, mu16);
        chk("corr_cnt_w2", bs.corr_cnt, mc2);
        chk("uncorr_cnt_w2", bs.uncorr_cnt, mu2);
        if (stalled_prev)
            chk("stall_hold", {bm.out_valid, bm.data_o, bm.err_corr, bm.err_uncorr, bm.err_pos},
                hold_v);
        if (oh) begin
            if (q.size() == 0) chk("out_without_input", oh, 0);
            else begin
                e = q.pop_front();
                chk("data_o", bm.data_o, e.data);
                chk("err_corr", bm.err_corr, e.corr);
                chk("err_uncorr", bm.err_uncorr, e.uncorr);
                chk("err_pos", bm.err_pos, e.pos);
                chk("latency", cyc_n, e.cyc + 2 + stall_n - e.stl);
                fc = e.corr;
                fu = e.uncorr;
            end
        end
        if (bm.cnt_clr) begin
            mc16 = 0; mu16 = 0; mc2 = 0; mu2 = 0;
        end else begin
            if (fc && mc16 < 65535) mc16++;
            if (fu && mu16 < 65535) mu16++;
            if (fc && mc2 < 3) mc2++;
            if (fu && mu2 < 3) mu2++;
        end
        if (ih) begin
            e = cur_exp;
            e.cyc = cyc_n;
            e.stl = stall_n;
            q.push_back(e);
        end
        if (!bm.in_ready) stall_n++;
        stalled_prev = bm.out_valid && !bm.out_ready;
        hold_v = {bm.out_valid, bm.data_o, bm.err_corr, bm.err_uncorr, bm.err_pos};
        last_in_hs = ih;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bm.out_valid, 0);
        chk("rst_data_o", bm.data_o, 0);
        chk("rst_err_corr", bm.err_corr, 0);
        chk("rst_err_uncorr", bm.err_uncorr, 0);
        chk("rst_err_pos", bm.err_pos, 0);
        chk("rst_corr_cnt", bm.corr_cnt, 0);
        chk("rst_uncorr_cnt", bm.uncorr_cnt, 0);
        q.delete();
        mc16 = 0; mu16 = 0; mc2 = 0; mu2 = 0;
        stalled_prev = 1'b0;
        last_in_hs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bm.in_ready, 1);
    endtask

    task automatic send(input logic [CW-1:0] code, input logic ce, input exp_t e);
        int n;
        n = 0;
        bm.in_valid = 1'b1;
        bm.code_i = code;
        bm.corr_en = ce;
        cur_exp = e;
        do begin
            cyc();
            n++;
        end while (!last_in_hs && n < 50);
        chk("send_accept", last_in_hs, 1);
        bm.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bm.in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] bp_code [4];
        exp_t          bp_exp [4];
        logic [DW-1:0] pl;
        logic [CW-1:0] mask;
        logic          ce;
        int sent, nflip, b1, b2, n;

        bm.in_valid = 1'b0;
        bm.code_i = '0;
        bm.corr_en = 1'b1;
        bm.cnt_clr = 1'b0;
        bm.out_ready = 1'b1;
        do_reset();

        send(15'h431A, 1'b1, mk(10'd50, 1'b0, 1'b0, 4'd0));
        send(15'h430A, 1'b1, mk(10'd50, 1'b1, 1'b0, 4'd5));
        send(15'h430A, 1'b0, mk(10'd48, 1'b1, 1'b0, 4'd5));
        send(15'h031A, 1'b1, mk(10'd50, 1'b1, 1'b0, 4'd0));
        send(15'h410A, 1'b1, mk(10'd16, 1'b0, 1'b1, 4'd15));
        send(15'h431A ^ 15'h0803, 1'b1, model(10'd50, 15'h0803, 1'b1));
        idle(4);
        chk("plan_corr_cnt", bm.corr_cnt, 3);
        chk("plan_uncorr_cnt", bm.uncorr_cnt, 2);

        for (int i = 0; i < 4; i++) begin
            pl = DW'($urandom);
            mask = (i == 1) ? 15'h0040 : '0;
            bp_code[i] = encode(pl) ^ mask;
            bp_exp[i] = model(pl, mask, 1'b1);
        end
        sent = 0;
        for (int k = 0; k < 12; k++) begin
            bm.out_ready = !(k >= 3 && k <= 5);
            bm.in_valid = (sent < 4);
            if (sent < 4) begin
                bm.code_i = bp_code[sent];
                cur_exp = bp_exp[sent];
            end
            cyc();
            if (last_in_hs) sent++;
        end
        bm.out_ready = 1'b1;
        chk("bp_all_sent", sent, 4);
        idle(3);

        for (int i = 0; i < 5; i++) send(15'h430A, 1'b1, mk(10'd50, 1'b1, 1'b0, 4'd5));
        idle(3);
        chk("sat_corr_cnt_w2", bs.corr_cnt, 3);
        send(15'h430A, 1'b1, mk(10'd50, 1'b1, 1'b0, 4'd5));
        cyc();
        chk("clr_word_at_output", bm.out_valid, 1);
        bm.cnt_clr = 1'b1;
        cyc();
        bm.cnt_clr = 1'b0;
        chk("clr_prio_cnt", bm.corr_cnt, 0);
        chk("clr_prio_cnt_w2", bs.corr_cnt, 0);
        idle(2);

        send(encode(10'd7), 1'b1, mk(10'd7, 1'b0, 1'b0, 4'd0));
        send(encode(10'd9), 1'b1, mk(10'd9, 1'b0, 1'b0, 4'd0));
        chk("pre_rst_out_valid", bm.out_valid, 1);
        do_reset();
        bm.in_valid = 1'b0;
        @(negedge clk);
        send(encode(10'd300), 1'b1, mk(10'd300, 1'b0, 1'b0, 4'd0));
        idle(3);

        for (int k = 0; k < 600; k++) begin
            if (!bm.in_valid || last_in_hs) begin
                pl = DW'($urandom);
                ce = 1'($urandom_range(0, 1));
                nflip = $urandom_range(0, 2);
                b1 = $urandom_range(0, CW - 1);
                b2 = (b1 + $urandom_range(1, CW - 1)) % CW;
                mask = '0;
                if (nflip >= 1) mask[b1] = 1'b1;
                if (nflip == 2) mask[b2] = 1'b1;
                bm.in_valid = ($urandom_range(0, 3) != 0);
                bm.code_i = encode(pl) ^ mask;
                bm.corr_en = ce;
                cur_exp = model(pl, mask, ce);
            end
            bm.out_ready = ($urandom_range(0, 3) != 0);
            bm.cnt_clr = ($urandom_range(0, 19) == 0);
            cyc();
        end
        bm.cnt_clr = 1'b0;
        bm.in_valid = 1'b0;
        bm.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
